fac_cell: RTL and testbench
===========================

Name: fac_cell

Overview:
- Single-bit full-adder cell: combinational core plus output register and stored-carry register.
- Used standalone, as one stage of a ripple chain (e.g. 4-bit end-around-carry adder), or as a bit-serial adder that feeds its own carry back.
- The two upstream lanes are `x` and `y`.
- Carry comes from an external input or from an internal carry register.

Parameters:
- REG_OUT, 1: 1 = `sum`/`cOut` registered with 1-cycle latency; 0 = combinational outputs.
- CARRY_RST, 0: reset value of the internal carry register (0 or 1; 1 supports two's-complement subtract by serial streaming).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- x  input  1  addend bit
- y  input  1  addend bit
- cIn  input  1  external carry-in
- in_valid  input  1  beat qualifier for x/y/cIn
- chain  input  1  1 = use stored carry `carry_q` instead of `cIn`
- sum  output  1  sum bit
- cOut  output  1  carry-out bit
- out_valid  output  1  `sum`/`cOut` hold a valid result
- carry_q  output  1  stored carry from the last accepted beat

Behaviour:
- One clock domain: `clk`. Reset `rst_n` is asynchronous and active-low.
- Effective carry: `c_eff = chain ? carry_q : cIn`.
- Arithmetic:
  - `s = x ^ y ^ c_eff`
  - `co = (x&y) | (x&c_eff) | (y&c_eff)`
  - All operands are 1 bit; no X propagation beyond the inputs.
- Carry register:
  - On a rising edge with `in_valid=1`: `carry_q <= co`.
  - Otherwise `carry_q` holds.
- REG_OUT=1:
  - On every rising edge: `out_valid <= in_valid`.
  - If `in_valid=1`: `sum <= s` and `cOut <= co`; otherwise both hold their last value.
  - Latency 1 cycle; throughput 1 beat/cycle.
- REG_OUT=0:
  - `sum = s`, `cOut = co`, `out_valid = in_valid`, all combinational.
  - `carry_q` is still registered as above.
- Reset (asserted at any time, including mid-stream):
  - Immediately forces `sum=0`, `cOut=0`, `out_valid=0`, `carry_q=CARRY_RST`.
  - The deassertion edge does not by itself update `carry_q`.
- `chain=1` on the first beat after reset uses `CARRY_RST` as the carry.
- `in_valid=0` cycles are bubbles: no state change except `out_valid` dropping to 0 (REG_OUT=1).
- Simultaneous `in_valid=1` and `chain=1` uses the pre-edge `carry_q`. The new carry is visible from the next cycle.
- No handshake back-pressure: every valid beat is accepted.

Optional Feature:
- Macro: FAC_OVF_EN.
- Defined:
  - Adds output port `ovf` (1 bit) = `c_eff ^ co`, i.e. signed overflow when this bit is the MSB.
  - Timing follows REG_OUT exactly like `cOut`: registered on valid beats, reset to 0.
- Undefined: no `ovf` port; no related logic.

Decomposition:
- Shared package `fac_pkg`: constants `FAC_CARRY_RST_DEFAULT=1'b0` and `FAC_REG_OUT_DEFAULT=1'b1`, plus the function `fac_majority(a,b,c)`.
- Sub-module `fac_core`: purely combinational full adder (`x`, `y`, `ci` -> `s`, `co`).
- `fac_cell` wraps `fac_core` with the carry-select mux, carry register and output stage.

Test Plan:
- Exhaustive combinational, `chain=0`, REG_OUT=1: all 8 combinations of x,y,cIn with `in_valid=1`. One cycle later, `{cOut,sum}` equals `x+y+cIn`. Checkpoints: 1,1,1 -> `cOut=1,sum=1`; 1,0,0 -> `0,1`; 0,0,0 -> `0,0`.
- Bit-serial add, `chain=1`, CARRY_RST=0: stream LSB first A=4'b0111, B=4'b0101. The sum bits are 0,0,1,1 (12 = 4'b1100) and the final `carry_q=0`. Repeat with 4'b1111+4'b0001: sum 0000, final `carry_q=1`.
- Bubbles: insert `in_valid=0` between the serial beats above. Result is unchanged, and `out_valid` is 0 in each bubble cycle.
- Reset mid-stream: after 2 beats with `carry_q=1`, pulse `rst_n=0` asynchronously between edges. `sum`, `cOut`, `out_valid` and `carry_q` go to 0 before the next edge. The next beat 1+0 with `chain=1` gives `sum=1`, `cOut=0`.
- REG_OUT=0: `x=1,y=1,cIn=0` -> `sum=0`, `cOut=1`, `out_valid=1` in the same cycle.
- FAC_OVF_EN defined: `x=0,y=0,c_eff=1` -> `ovf=1`; `x=1,y=1,c_eff=1` -> `ovf=0`.

Source files
------------

// File: rtl/fac_pkg.sv
// fac_pkg: shared constants and helpers for the full-adder cell.
//   FAC_CARRY_RST_DEFAULT : default reset value of the stored carry
//   FAC_REG_OUT_DEFAULT   : default output-register enable
//   fac_majority(a,b,c)   : 2-of-3 majority, i.e. full-adder carry
package fac_pkg;

  localparam bit FAC_CARRY_RST_DEFAULT = 1'b0;
  localparam bit FAC_REG_OUT_DEFAULT   = 1'b1;

  function automatic logic fac_majority(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/fac_core.sv
// fac_core: purely combinational single-bit full adder.
// Ports:
//   x, y : addend bits
//   ci   : carry-in
//   s    : sum bit
//   co   : carry-out bit
module fac_core
  import fac_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = fac_majority(x, y, ci);

endmodule

// File: rtl/fac_cell.sv
// fac_cell: full-adder cell with carry-select, stored-carry register and an
// optional output register. Usable standalone, in a ripple chain, or as a
// bit-serial adder feeding its own carry back (chain=1).
// Parameters:
//   REG_OUT   : 1 = sum/cOut/out_valid registered (1-cycle latency),
//               0 = combinational outputs
//   CARRY_RST : reset value of carry_q
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   x, y, cIn  : addend bits and external carry-in
//   in_valid   : beat qualifier
//   chain      : 1 = use carry_q instead of cIn
//   sum, cOut  : result bits
//   out_valid  : sum/cOut hold a valid result
//   carry_q    : stored carry of the last accepted beat
//   ovf        : signed overflow (c_eff ^ co), only with FAC_OVF_EN defined
// Optional feature macro: FAC_OVF_EN
module fac_cell
  import fac_pkg::*;
#(
  parameter bit REG_OUT   = FAC_REG_OUT_DEFAULT,
  parameter bit CARRY_RST = FAC_CARRY_RST_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic x,
  input  logic y,
  input  logic cIn,
  input  logic in_valid,
  input  logic chain,
  output logic sum,
  output logic cOut,
  output logic out_valid,
  output logic carry_q
`ifdef FAC_OVF_EN
  ,
  output logic ovf
`endif
);

  logic c_eff;
  logic s;
  logic co;

  // Carry select: stored carry for serial/self-chained operation.
  assign c_eff = chain ? carry_q : cIn;

  fac_core u_core (
    .x  (x),
    .y  (y),
    .ci (c_eff),
    .s  (s),
    .co (co)
  );

  // Stored carry updates only on accepted beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q <= CARRY_RST;
    end else if (in_valid) begin
      carry_q <= co;
    end
  end

  if (REG_OUT) begin : g_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum       <= 1'b0;
        cOut      <= 1'b0;
        out_valid <= 1'b0;
      end else begin
        out_valid <= in_valid;
        if (in_valid) begin
          sum  <= s;
          cOut <= co;
        end
      end
    end
`ifdef FAC_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ovf <= 1'b0;
      end else if (in_valid) begin
        ovf <= c_eff ^ co;
      end
    end
`endif
  end else begin : g_comb
    // Gated by rst_n so reset forces outputs low even in combinational mode.
    always_comb begin
      sum       = rst_n & s;
      cOut      = rst_n & co;
      out_valid = rst_n & in_valid;
    end
`ifdef FAC_OVF_EN
    always_comb begin
      ovf = rst_n & (c_eff ^ co);
    end
`endif
  end

endmodule

// File: tb/tb_fac_cell.sv
// tb_fac_cell: scoreboard bench for fac_cell. Registered instance (dut) is
// checked by a monitor popping expected records; a combinational instance
// (dut_c, REG_OUT=0) shares the inputs and is checked in the drive cycle.
module tb_fac_cell;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic x = 1'b0, y = 1'b0, cin = 1'b0, in_valid = 1'b0, chain = 1'b0;
  logic sum, cout, out_valid, carry_q;
  logic sum_c, cout_c, out_valid_c, carry_q_c;
`ifdef FAC_OVF_EN
  logic ovf, ovf_c;
`endif

  always #5 clk = ~clk;

  fac_cell #(.REG_OUT(1'b1), .CARRY_RST(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .cIn(cin), .in_valid(in_valid),
    .chain(chain), .sum(sum), .cOut(cout), .out_valid(out_valid), .carry_q(carry_q)
`ifdef FAC_OVF_EN
    , .ovf(ovf)
`endif
  );

  fac_cell #(.REG_OUT(1'b0), .CARRY_RST(1'b0)) dut_c (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .cIn(cin), .in_valid(in_valid),
    .chain(chain), .sum(sum_c), .cOut(cout_c), .out_valid(out_valid_c), .carry_q(carry_q_c)
`ifdef FAC_OVF_EN
    , .ovf(ovf_c)
`endif
  );

  typedef struct packed {
    logic v;
    logic s;
    logic co;
    logic cq;
    logic ov;
  } exp_t;

  exp_t q[$];
  logic [1:0] obs[$];
  exp_t me;
  int checks = 0;
  int errors = 0;
  logic mc = 1'b0;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: one expected record per driven cycle, sampled after the edge.
  always @(posedge clk) begin
    #2;
    if (q.size() > 0) begin
      me = q.pop_front();
      chk("out_valid", 4'(out_valid), 4'(me.v));
      if (me.v) begin
        chk("sum", 4'(sum), 4'(me.s));
        chk("cOut", 4'(cout), 4'(me.co));
`ifdef FAC_OVF_EN
        chk("ovf", 4'(ovf), 4'(me.ov));
`endif
        obs.push_back({cout, sum});
      end
      chk("carry_q", 4'(carry_q), 4'(me.cq));
    end
  end

  task automatic beat(input logic bx, input logic by, input logic bc,
                      input logic bch, input logic bv);
    logic ce;
    logic [1:0] tot;
    exp_t e;
    @(negedge clk);
    x = bx; y = by; cin = bc; chain = bch; in_valid = bv;
    ce = bch ? mc : bc;
    tot = 2'(bx) + 2'(by) + 2'(ce);
    if (bv) begin
      e = '{v: 1'b1, s: tot[0], co: tot[1], cq: tot[1], ov: ce ^ tot[1]};
      mc = tot[1];
    end else begin
      e = '{v: 1'b0, s: 1'b0, co: 1'b0, cq: mc, ov: 1'b0};
    end
    q.push_back(e);
    #1;
    chk("c_out_valid", 4'(out_valid_c), 4'(bv));
    if (bv) begin
      chk("c_sum", 4'(sum_c), 4'(tot[0]));
      chk("c_cOut", 4'(cout_c), 4'(tot[1]));
`ifdef FAC_OVF_EN
      chk("c_ovf", 4'(ovf_c), 4'(ce ^ tot[1]));
`endif
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    beat(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    while (q.size() > 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #3;
    if (q.size() > 0) begin
      chk("drain_timeout", 4'(q.size()), 4'd0);
      q.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    mc = 1'b0;
  endtask

  logic [3:0] r;

  initial begin
    #3;
    chk("rst_sum", 4'(sum), 4'd0);
    chk("rst_cOut", 4'(cout), 4'd0);
    chk("rst_out_valid", 4'(out_valid), 4'd0);
    chk("rst_carry_q", 4'(carry_q), 4'd0);
    chk("rst_c_out_valid", 4'(out_valid_c), 4'd0);
    #1 rst_n = 1'b1;

    // Exhaustive x,y,cIn with external carry.
    obs.delete();
    for (int i = 0; i < 8; i++) begin
      r = 4'(i);
      beat(r[2], r[1], r[0], 1'b0, 1'b1);
    end
    drain();
    chk("exh_count", 4'(obs.size()), 4'd8);
    if (obs.size() == 8) begin
      chk("exh_111", 4'(obs[7]), 4'b0011);
      chk("exh_100", 4'(obs[4]), 4'b0001);
      chk("exh_000", 4'(obs[0]), 4'b0000);
    end

    // Bit-serial 0111 + 0101 = 1100.
    do_reset();
    obs.delete();
    beat(1, 1, 0, 1, 1); beat(1, 0, 0, 1, 1); beat(1, 1, 0, 1, 1); beat(0, 0, 0, 1, 1);
    drain();
    chk("ser1_count", 4'(obs.size()), 4'd4);
    if (obs.size() == 4) begin
      r = {obs[3][0], obs[2][0], obs[1][0], obs[0][0]};
      chk("ser1_sum", r, 4'hC);
    end
    chk("ser1_carry", 4'(carry_q), 4'd0);

    // Bit-serial 1111 + 0001 = 0000 carry 1.
    do_reset();
    obs.delete();
    beat(1, 1, 0, 1, 1); beat(1, 0, 0, 1, 1); beat(1, 0, 0, 1, 1); beat(1, 0, 0, 1, 1);
    drain();
    if (obs.size() == 4) begin
      r = {obs[3][0], obs[2][0], obs[1][0], obs[0][0]};
      chk("ser2_sum", r, 4'h0);
    end else begin
      chk("ser2_count", 4'(obs.size()), 4'd4);
    end
    chk("ser2_carry", 4'(carry_q), 4'd1);

    // Bubbles between serial beats must not disturb the result.
    do_reset();
    obs.delete();
    beat(1, 1, 0, 1, 1); beat(0, 0, 0, 0, 0);
    beat(1, 0, 0, 1, 1); beat(0, 0, 0, 0, 0); beat(0, 0, 0, 0, 0);
    beat(1, 1, 0, 1, 1); beat(0, 0, 0, 0, 0);
    beat(0, 0, 0, 1, 1);
    drain();
    if (obs.size() == 4) begin
      r = {obs[3][0], obs[2][0], obs[1][0], obs[0][0]};
      chk("bub_sum", r, 4'hC);
    end else begin
      chk("bub_count", 4'(obs.size()), 4'd4);
    end
    chk("bub_carry", 4'(carry_q), 4'd0);

    // Asynchronous reset mid-stream with carry_q=1.
    do_reset();
    beat(1, 1, 0, 1, 1); beat(1, 0, 0, 1, 1);
    drain();
    chk("pre_rst_carry", 4'(carry_q), 4'd1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_sum", 4'(sum), 4'd0);
    chk("mid_rst_cOut", 4'(cout), 4'd0);
    chk("mid_rst_out_valid", 4'(out_valid), 4'd0);
    chk("mid_rst_carry_q", 4'(carry_q), 4'd0);
    chk("mid_rst_c_sum", 4'(sum_c), 4'd0);
    rst_n = 1'b1;
    mc = 1'b0;
    obs.delete();
    beat(1, 0, 0, 1, 1);
    drain();
    if (obs.size() == 1) chk("post_rst_beat", 4'(obs[0]), 4'b0001);
    else chk("post_rst_count", 4'(obs.size()), 4'd1);

    // Combinational instance checkpoint: 1+1+0 in the same cycle.
    beat(1, 1, 0, 0, 1);
    chk("comb_cOut_110", 4'(cout_c), 4'd1);
    chk("comb_sum_110", 4'(sum_c), 4'd0);
    drain();

`ifdef FAC_OVF_EN
    do_reset();
    obs.delete();
    beat(0, 0, 1, 0, 1);
    beat(1, 1, 1, 0, 1);
    drain();
    chk("ovf_000_1", 4'(obs.size()), 4'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
